// File: rtl/mte_pkg.sv
// Shared types and constants for the MTE byte feeder.
package mte_pkg;

    localparam int unsigned FRAME_BYTES_DEFAULT = 32;

    localparam logic [7:0] PAD_BYTE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/mte_byte_fifo.sv
// Synchronous FIFO with a combinational head read and wrap-bit pointers.
module mte_byte_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the head slot in the same cycle, so push is allowed when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mte_byte_feeder.sv
// Buffers upstream bytes and presents fixed-size, key-stable frames to MTE,
// zero-padding frames that end early.
module mte_byte_feeder
    import mte_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [7:0]                   key_in,
    input  logic                         key_load,
    input  logic                         mode_in,
    input  logic                         s_valid,
    input  logic [7:0]                   s_data,
    input  logic                         s_last,
    output logic                         s_ready,
    input  logic                         m_ready,
    output logic                         m_valid,
    output logic [7:0]                   m_data,
    output logic [7:0]                   m_key,
    output logic                         m_sel,
    output logic [$clog2(FRAME_BYTES):0] byte_cnt,
    output logic                         frame_done,
    output logic                         short_frame
);

    localparam int unsigned CW = $clog2(FRAME_BYTES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BYTES - 1);

    feeder_state_t state;
    feeder_state_t state_next;

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic [8:0] fifo_rdata;

    logic [7:0] key_reg;
    logic       key_ok;
    logic       short_flag;
    logic       start;
    logic       count_en;
    logic       set_short;
    logic       cnt_is_last;

    assign s_ready     = !fifo_full;
    assign fifo_push   = s_valid && s_ready;
    assign cnt_is_last = (byte_cnt == CNT_LAST);

    mte_byte_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({s_last, s_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state decode and downstream handshake outputs.
    always_comb begin
        state_next  = state;
        m_valid     = 1'b0;
        m_data      = PAD_BYTE;
        fifo_pop    = 1'b0;
        frame_done  = 1'b0;
        short_frame = 1'b0;
        start       = 1'b0;
        count_en    = 1'b0;
        set_short   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (key_ok && !fifo_empty) begin
                    start      = 1'b1;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!fifo_empty) begin
                    m_valid = 1'b1;
                    m_data  = fifo_rdata[7:0];
                    if (m_ready) begin
                        fifo_pop = 1'b1;
                        count_en = 1'b1;
                        if (cnt_is_last) begin
                            state_next = ST_DONE;
                        end else if (fifo_rdata[8]) begin
                            set_short  = 1'b1;
                            state_next = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    count_en = 1'b1;
                    if (cnt_is_last) state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                short_frame = short_flag;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Key register, per-frame key/mode latch, byte counter and short-frame flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_reg    <= '0;
            key_ok     <= 1'b0;
            m_key      <= '0;
            m_sel      <= 1'b0;
            byte_cnt   <= '0;
            short_flag <= 1'b0;
        end else begin
            if (key_load) begin
                key_reg <= key_in;
                key_ok  <= 1'b1;
            end
            if (start) begin
                m_key      <= key_reg;
                m_sel      <= mode_in;
                byte_cnt   <= '0;
                short_flag <= 1'b0;
            end else begin
                if (count_en)  byte_cnt   <= byte_cnt + CW'(1);
                if (set_short) short_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mte_byte_feeder.sv
// Directed bench for mte_byte_feeder with hand-computed expectations.
module tb_mte_byte_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_in = '0;
    logic       key_load = 1'b0;
    logic       mode_in = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       m_ready = 1'b1;
    logic       m_valid;
    logic [7:0] m_data;
    logic [7:0] m_key;
    logic       m_sel;
    logic [5:0] byte_cnt;
    logic       frame_done;
    logic       short_frame;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] out_data[$];
    logic [7:0] out_key[$];
    logic       out_sel[$];
    int         out_cyc[$];
    logic       done_short[$];

    mte_byte_feeder #(.FRAME_BYTES(32), .FIFO_DEPTH(8)) dut (
        .clock       (clk),
        .reset       (rst),
        .key_in      (key_in),
        .key_load    (key_load),
        .mode_in     (mode_in),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_key       (m_key),
        .m_sel       (m_sel),
        .byte_cnt    (byte_cnt),
        .frame_done  (frame_done),
        .short_frame (short_frame)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record downstream transfers and frame_done pulses mid-cycle.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            out_data.push_back(m_data);
            out_key.push_back(m_key);
            out_sel.push_back(m_sel);
            out_cyc.push_back(cyc);
        end
        if (frame_done) done_short.push_back(short_frame);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        out_data.delete();
        out_key.delete();
        out_sel.delete();
        out_cyc.delete();
        done_short.delete();
    endtask

    task automatic load_key(input logic [7:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        int k = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) check("push_timeout", {31'd0, s_ready}, 1);
        tick();
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_short.size() == 0 && k < 500) begin
            tick();
            k++;
        end
        if (k >= 500) check(tag, done_short.size(), 1);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},  {31'd0, s_ready}, 1);
        check({tag, "_m_valid"},  {31'd0, m_valid}, 0);
        check({tag, "_m_data"},   {24'd0, m_data}, 0);
        check({tag, "_m_key"},    {24'd0, m_key}, 0);
        check({tag, "_m_sel"},    {31'd0, m_sel}, 0);
        check({tag, "_byte_cnt"}, {26'd0, byte_cnt}, 0);
        check({tag, "_done"},     {31'd0, frame_done}, 0);
        check({tag, "_short"},    {31'd0, short_frame}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int nd;

        // Reset values
        #2;
        check_reset_outputs("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Full 32-byte frame, encrypt, key 0x5A
        clear_log();
        mode_in = 1'b1;
        m_ready = 1'b1;
        load_key(8'h5A);
        for (int i = 0; i < 32; i++) push_byte(8'(i), i == 31);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done("t1_done_timeout");
        check("t1_count", out_data.size(), 32);
        bad = 0;
        for (int i = 0; i < out_data.size(); i++) begin
            if (out_data[i] !== 8'(i)) bad++;
            if (out_key[i] !== 8'h5A)  bad++;
            if (out_sel[i] !== 1'b1)   bad++;
        end
        check("t1_data_key_sel_bad", bad, 0);
        if (out_cyc.size() == 32) check("t1_consecutive", out_cyc[31] - out_cyc[0], 31);
        check("t1_done_cnt", done_short.size(), 1);
        if (done_short.size() > 0) check("t1_short", {31'd0, done_short[0]}, 0);
        check("t1_byte_cnt", {26'd0, byte_cnt}, 32);

        // Short frame of 5 bytes; includes a one-cycle latency probe
        clear_log();
        mode_in = 1'b0;
        push_byte(8'hA0, 1'b0);
        s_valid = 1'b0;
        for (int k = 0; k < 50 && out_data.size() == 0; k++) tick();
        tick();
        tick();
        s_valid = 1'b1;
        s_data  = 8'hA1;
        s_last  = 1'b0;
        tick();
        s_valid = 1'b0;
        check("t2_lat_valid", {31'd0, m_valid}, 1);
        check("t2_lat_data", {24'd0, m_data}, 32'hA1);
        push_byte(8'hA2, 1'b0);
        push_byte(8'hA3, 1'b0);
        push_byte(8'hA4, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done("t2_done_timeout");
        check("t2_count", out_data.size(), 32);
        bad = 0;
        for (int i = 0; i < out_data.size(); i++) begin
            if (i < 5) begin
                if (out_data[i] !== 8'hA0 + 8'(i)) bad++;
            end else if (out_data[i] !== 8'h00) begin
                bad++;
            end
            if (out_sel[i] !== 1'b0) bad++;
        end
        check("t2_data_pad_bad", bad, 0);
        check("t2_done_cnt", done_short.size(), 1);
        if (done_short.size() > 0) check("t2_short", {31'd0, done_short[0]}, 1);
        check("t2_byte_cnt", {26'd0, byte_cnt}, 32);

        // Back-pressure: 8 bytes fill the buffer, the 9th waits
        clear_log();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i), 1'b0);
        check("t3_full_s_ready", {31'd0, s_ready}, 0);
        check("t3_held_valid", {31'd0, m_valid}, 1);
        check("t3_held_data", {24'd0, m_data}, 32'hC0);
        check("t3_no_xfer", out_data.size(), 0);
        m_ready = 1'b1;
        push_byte(8'hC8, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done("t3_done_timeout");
        check("t3_count", out_data.size(), 32);
        bad = 0;
        for (int i = 0; i < out_data.size(); i++) begin
            if (i < 9) begin
                if (out_data[i] !== 8'hC0 + 8'(i)) bad++;
            end else if (out_data[i] !== 8'h00) begin
                bad++;
            end
        end
        check("t3_order_bad", bad, 0);
        if (done_short.size() > 0) check("t3_short", {31'd0, done_short[0]}, 1);

        // Mid-frame key_load applies to the following frame only
        clear_log();
        load_key(8'h11);
        for (int i = 0; i < 32; i++) begin
            key_in   = 8'h77;
            key_load = (i == 10);
            push_byte(8'h40 + 8'(i), i == 31);
            key_load = 1'b0;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done("t5_done_timeout");
        bad = 0;
        for (int i = 0; i < out_key.size(); i++) if (out_key[i] !== 8'h11) bad++;
        check("t5_key_old_bad", bad, 0);
        check("t5_count", out_key.size(), 32);
        clear_log();
        push_byte(8'h99, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done("t5b_done_timeout");
        bad = 0;
        for (int i = 0; i < out_key.size(); i++) if (out_key[i] !== 8'h77) bad++;
        check("t5_key_new_bad", bad, 0);
        if (out_data.size() > 0) check("t5_new_data", {24'd0, out_data[0]}, 32'h99);

        // Reset at byte 20 of a frame
        clear_log();
        mode_in = 1'b1;
        for (int i = 0; i < 20; i++) push_byte(8'(i), 1'b0);
        s_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        tick();
        rst = 1'b0;
        nd = done_short.size();

        // No key after reset: bytes buffer but no frame starts
        clear_log();
        push_byte(8'hE0, 1'b0);
        push_byte(8'hE1, 1'b0);
        push_byte(8'hE2, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        check("t4_no_xfer", out_data.size(), 0);
        check("t4_no_done", done_short.size(), 0);
        check("t6_no_done_at_rst", nd, 0);
        check("t4_valid_low", {31'd0, m_valid}, 0);
        load_key(8'h33);
        wait_done("t4_done_timeout");
        check("t4_count", out_data.size(), 32);
        bad = 0;
        for (int i = 0; i < out_data.size(); i++) begin
            if (out_key[i] !== 8'h33) bad++;
            if (out_sel[i] !== 1'b1)  bad++;
            if (i < 3) begin
                if (out_data[i] !== 8'hE0 + 8'(i)) bad++;
            end else if (out_data[i] !== 8'h00) begin
                bad++;
            end
        end
        check("t4_frame_bad", bad, 0);
        check("t4_m_key", {24'd0, m_key}, 32'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
